// File: rtl/sr_pulse_debouncer_pkg.sv
// sr_pulse_debouncer_pkg: shared FSM states, idle output levels and counter sizing
package sr_pkg;
  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;
  localparam logic S_IDLE = 1'b1;
  localparam logic R_IDLE = 1'b1;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sr_pulse_debouncer_if.sv
// sr_pulse_debouncer_if: button inputs and latch drive outputs of the debouncer
interface sr_pulse_debouncer_if;
  logic set_btn;
  logic rst_btn;
  logic s;
  logic r;
  logic busy;
  logic conflict;
  modport master(output set_btn, rst_btn, input s, r, busy, conflict);
  modport slave(input set_btn, rst_btn, output s, r, busy, conflict);
endinterface

// File: rtl/sr_pulse_debouncer_debounce_ch.sv
// debounce_ch: synchronizer, debounce counter and rising-edge request for one button
module debounce_ch import sr_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_req
);
  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_deb;
  logic r_req;
  logic w_sync;
  logic w_flip;
  assign w_sync = r_sync[SYNC_STAGES-1];
  // the level flips on the edge that would complete DEB_CYCLES mismatching samples
  assign w_flip = (w_sync != r_deb) && (r_cnt == C_LAST);
  assign o_req = r_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
      r_req  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_cnt  <= (w_sync == r_deb || w_flip) ? '0 : r_cnt + 1'b1;
      r_deb  <= r_deb ^ w_flip;
      r_req  <= w_flip & ~r_deb;
    end
  end
endmodule

// File: rtl/sr_pulse_debouncer.sv
// sr_pulse_debouncer: turns two bouncing buttons into clean, exclusive active-low S/R latch pulses
module sr_pulse_debouncer import sr_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int PULSE_W     = 2
) (
  input logic clk,
  input logic rst,
  sr_pulse_debouncer_if.slave bus
);
  localparam int PW = cnt_w(PULSE_W);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_W - 1);
  state_t r_state;
  logic [PW-1:0] r_pcnt;
  logic r_pend_s, r_pend_r, r_s, r_r, r_busy, r_conflict;
  logic w_req_s, w_req_r, w_idle, w_take_s, w_take_r;
  debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_set (
    .clk(clk), .rst(rst), .i_btn(bus.set_btn), .o_req(w_req_s)
  );
  debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_rst (
    .clk(clk), .rst(rst), .i_btn(bus.rst_btn), .o_req(w_req_r)
  );
  assign w_idle   = r_state == IDLE;
  assign w_take_s = w_idle & r_pend_s & ~r_pend_r;
  assign w_take_r = w_idle & r_pend_r & ~r_pend_s;
  assign bus.s        = r_s;
  assign bus.r        = r_r;
  assign bus.busy     = r_busy;
  assign bus.conflict = r_conflict;
  // an IDLE cycle always consumes pending flags: accepted, or discarded as a conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_s        <= S_IDLE;
      r_r        <= R_IDLE;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_pend_s   <= w_req_s | (r_pend_s & ~w_idle);
      r_pend_r   <= w_req_r | (r_pend_r & ~w_idle);
      r_conflict <= w_idle & r_pend_s & r_pend_r;
      case (r_state)
        IDLE: begin
          r_pcnt <= '0;
          if (w_take_s) begin
            r_state <= PULSE_S;
            r_s     <= 1'b0;
            r_busy  <= 1'b1;
          end else if (w_take_r) begin
            r_state <= PULSE_R;
            r_r     <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          r_pcnt <= r_pcnt + 1'b1;
          if (r_pcnt == P_LAST) begin
            r_state <= GAP;
            r_s     <= S_IDLE;
            r_r     <= R_IDLE;
          end
        end
        GAP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sr_pulse_debouncer.sv
// tb_sr_pulse_debouncer: directed scenarios for the S/R pulse debouncer
module tb_sr_pulse_debouncer;
  logic clk;
  logic rst;
  int checks = 0;
  int failures = 0;
  int s_first, s_cnt, s_last, r_first, r_cnt, r_last, b_first, b_cnt, c_first, c_cnt;
  sr_pulse_debouncer_if ifc();
  sr_pulse_debouncer dut (.clk(clk), .rst(rst), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if (ifc.s === 1'b0 && ifc.r === 1'b0) begin
      failures++;
      $display("FAIL sr_exclusive t=%0t s=%b r=%b required not both 0", $time, ifc.s, ifc.r);
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    ifc.set_btn = 1'b0;
    ifc.rst_btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  // bit i of each pattern is applied before edge i; sample i is taken after edge i
  task automatic watch(input int n, input logic [63:0] ps, input logic [63:0] pr, input logic [63:0] pk);
    s_first = -1; s_cnt = 0; s_last = -1; r_first = -1; r_cnt = 0; r_last = -1;
    b_first = -1; b_cnt = 0; c_first = -1; c_cnt = 0;
    for (int i = 0; i < n; i++) begin
      ifc.set_btn = ps[i];
      ifc.rst_btn = pr[i];
      rst = pk[i];
      @(posedge clk);
      @(negedge clk);
      if (ifc.s === 1'b0) begin if (s_first < 0) s_first = i; s_last = i; s_cnt++; end
      if (ifc.r === 1'b0) begin if (r_first < 0) r_first = i; r_last = i; r_cnt++; end
      if (ifc.busy === 1'b1) begin if (b_first < 0) b_first = i; b_cnt++; end
      if (ifc.conflict === 1'b1) begin if (c_first < 0) c_first = i; c_cnt++; end
    end
    ifc.set_btn = 1'b0;
    ifc.rst_btn = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.set_btn = i[0];
      ifc.rst_btn = ~i[0];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ifc.s, ifc.r, ifc.busy, ifc.conflict} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got s/r/busy/conflict=%b%b%b%b exp=1100", i, ifc.s, ifc.r, ifc.busy, ifc.conflict);
      end
    end
    watch(20, 64'h0, 64'h0, 64'h0);
    checks++;
    if (s_cnt + r_cnt + b_cnt + c_cnt !== 0) begin
      failures++;
      $display("FAIL reset_quiet got s_lo=%0d r_lo=%0d busy=%0d conflict=%0d exp all 0", s_cnt, r_cnt, b_cnt, c_cnt);
    end
  endtask
  task automatic test_clean_set();
    do_reset();
    watch(40, 64'hFFFFF, 64'h0, 64'h0);
    checks++;
    if (s_first !== 7) begin failures++; $display("FAIL clean_s_first got=%0d exp=7", s_first); end
    checks++;
    if (s_cnt !== 2 || s_last !== 8) begin failures++; $display("FAIL clean_s_width got cnt=%0d last=%0d exp cnt=2 last=8", s_cnt, s_last); end
    checks++;
    if (b_first !== 7 || b_cnt !== 3) begin failures++; $display("FAIL clean_busy got first=%0d cnt=%0d exp first=7 cnt=3", b_first, b_cnt); end
    checks++;
    if (r_cnt !== 0 || c_cnt !== 0) begin failures++; $display("FAIL clean_no_r got r_lo=%0d conflict=%0d exp 0 0", r_cnt, c_cnt); end
  endtask
  task automatic test_bounce();
    do_reset();
    watch(40, 64'h7FEED, 64'h0, 64'h0);
    checks++;
    if (s_first !== 16) begin failures++; $display("FAIL bounce_s_first got=%0d exp=16", s_first); end
    checks++;
    if (s_cnt !== 2 || s_last !== 17) begin failures++; $display("FAIL bounce_s_width got cnt=%0d last=%0d exp cnt=2 last=17", s_cnt, s_last); end
    checks++;
    if (b_cnt !== 3 || r_cnt !== 0) begin failures++; $display("FAIL bounce_busy got busy=%0d r_lo=%0d exp 3 0", b_cnt, r_cnt); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    watch(30, 64'hFFFFF, 64'hFFFFF, 64'h0);
    checks++;
    if (c_first !== 7 || c_cnt !== 1) begin failures++; $display("FAIL simul_conflict got first=%0d cnt=%0d exp first=7 cnt=1", c_first, c_cnt); end
    checks++;
    if (s_cnt !== 0 || r_cnt !== 0) begin failures++; $display("FAIL simul_no_pulse got s_lo=%0d r_lo=%0d exp 0 0", s_cnt, r_cnt); end
    checks++;
    if (b_cnt !== 0) begin failures++; $display("FAIL simul_busy got=%0d exp=0", b_cnt); end
  endtask
  task automatic test_overlap();
    do_reset();
    watch(40, 64'hFFFFF, 64'hFFFFC, 64'h0);
    checks++;
    if (s_first !== 7 || s_cnt !== 2) begin failures++; $display("FAIL overlap_s got first=%0d cnt=%0d exp first=7 cnt=2", s_first, s_cnt); end
    checks++;
    if (r_first !== 11 || r_cnt !== 2 || r_last !== 12) begin
      failures++;
      $display("FAIL overlap_r got first=%0d cnt=%0d last=%0d exp 11 2 12", r_first, r_cnt, r_last);
    end
    checks++;
    if (b_first !== 7 || b_cnt !== 6) begin failures++; $display("FAIL overlap_busy got first=%0d cnt=%0d exp first=7 cnt=6", b_first, b_cnt); end
    checks++;
    if (c_cnt !== 0) begin failures++; $display("FAIL overlap_conflict got=%0d exp=0", c_cnt); end
  endtask
  task automatic test_reset_mid_pulse();
    do_reset();
    watch(40, 64'h0, 64'hF, 64'h100);
    checks++;
    if (r_first !== 7 || r_cnt !== 1) begin failures++; $display("FAIL midrst_r got first=%0d cnt=%0d exp first=7 cnt=1", r_first, r_cnt); end
    checks++;
    if (b_cnt !== 1) begin failures++; $display("FAIL midrst_busy got=%0d exp=1", b_cnt); end
    checks++;
    if (s_cnt !== 0 || c_cnt !== 0) begin failures++; $display("FAIL midrst_quiet got s_lo=%0d conflict=%0d exp 0 0", s_cnt, c_cnt); end
  endtask
  initial begin
    rst = 1'b1;
    ifc.set_btn = 1'b0;
    ifc.rst_btn = 1'b0;
    test_reset();
    test_clean_set();
    test_bounce();
    test_simultaneous();
    test_overlap();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
